stage6: RTL and testbench

- Normalization stage directly downstream of the coefficient×pixel multiply stage.
- Consumes the nine 16-bit weighted products and the nine 8-bit coefficients that the multiply stage emits, and forms numerator = Σcp and denominator = Σc.
- Computes the 8-bit filtered pixel = round(numerator/denominator) with a multi-cycle restoring divider.
- Uses a valid/ready handshake on both sides, because the divider cannot accept a new window every cycle.

---
 rtl/stage6.sv | 131 +++++++++++++
 tb/tb_stage6.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage6.sv
// Normalization stage: pixel = round(sum(c*p) / sum(c)), using a restoring divider.
// Latency: 10 edges from accept to out_valid (den!=0) or 2 edges (den==0); in_ready only in IDLE; DONE holds until out_ready.
module stage6 #(
    parameter bit ROUND = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] cp1,
    input  logic [15:0] cp2,
    input  logic [15:0] cp3,
    input  logic [15:0] cp4,
    input  logic [15:0] cp5,
    input  logic [15:0] cp6,
    input  logic [15:0] cp7,
    input  logic [15:0] cp8,
    input  logic [15:0] cp9,
    input  logic [7:0]  c1,
    input  logic [7:0]  c2,
    input  logic [7:0]  c3,
    input  logic [7:0]  c4,
    input  logic [7:0]  c5,
    input  logic [7:0]  c6,
    input  logic [7:0]  c7,
    input  logic [7:0]  c8,
    input  logic [7:0]  c9,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  pix_out,
    output logic        div_zero
);

    typedef enum logic [1:0] {IDLE, ACC, DIV, DONE} state_t;

    state_t      state;
    logic [17:0] ps0, ps1, ps2;
    logic [9:0]  cs0, cs1, cs2;
    logic [11:0] den;
    logic [19:0] rem;
    logic [2:0]  cnt;
    logic [7:0]  q;

    logic [11:0] den_w;
    logic [19:0] num_w;
    logic [19:0] den_sh;
    logic        ge;
    logic [19:0] rem_sub;

    assign in_ready = (state == IDLE);

    always_comb begin
        den_w   = {2'b00, cs0} + {2'b00, cs1} + {2'b00, cs2};
        num_w   = {2'b00, ps0} + {2'b00, ps1} + {2'b00, ps2};
        // Bias by half the divisor so the truncating divide rounds to nearest.
        if (ROUND)
            num_w = num_w + {9'd0, den_w[11:1]};
        den_sh  = {8'd0, den} << cnt;
        ge      = (rem >= den_sh);
        rem_sub = rem - den_sh;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ps0       <= '0;
            ps1       <= '0;
            ps2       <= '0;
            cs0       <= '0;
            cs1       <= '0;
            cs2       <= '0;
            den       <= '0;
            rem       <= '0;
            cnt       <= '0;
            q         <= '0;
            out_valid <= 1'b0;
            pix_out   <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ps0   <= {2'b00, cp1} + {2'b00, cp2} + {2'b00, cp3};
                        ps1   <= {2'b00, cp4} + {2'b00, cp5} + {2'b00, cp6};
                        ps2   <= {2'b00, cp7} + {2'b00, cp8} + {2'b00, cp9};
                        cs0   <= {2'b00, c1} + {2'b00, c2} + {2'b00, c3};
                        cs1   <= {2'b00, c4} + {2'b00, c5} + {2'b00, c6};
                        cs2   <= {2'b00, c7} + {2'b00, c8} + {2'b00, c9};
                        state <= ACC;
                    end
                end
                ACC: begin
                    den <= den_w;
                    if (den_w == 12'd0) begin
                        pix_out   <= '0;
                        div_zero  <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        div_zero <= 1'b0;
                        rem      <= num_w;
                        cnt      <= 3'd7;
                        q        <= '0;
                        state    <= DIV;
                    end
                end
                DIV: begin
                    if (ge)
                        rem <= rem_sub;
                    // Quotient bits arrive MSB first, so shift them in from the right.
                    q <= {q[6:0], ge};
                    if (cnt == 3'd0) begin
                        pix_out   <= {q[6:0], ge};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stage6.sv
// Directed bench for stage6: two instances (rounding and truncating) share the same stimulus.
module tb_stage6;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] cp [9];
    logic [7:0]  c  [9];
    logic        in_ready, out_valid, div_zero;
    logic [7:0]  pix_out;
    logic        in_ready_t, out_valid_t, div_zero_t;
    logic [7:0]  pix_out_t;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stage6 #(.ROUND(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .cp1(cp[0]), .cp2(cp[1]), .cp3(cp[2]), .cp4(cp[3]), .cp5(cp[4]),
        .cp6(cp[5]), .cp7(cp[6]), .cp8(cp[7]), .cp9(cp[8]),
        .c1(c[0]), .c2(c[1]), .c3(c[2]), .c4(c[3]), .c5(c[4]),
        .c6(c[5]), .c7(c[6]), .c8(c[7]), .c9(c[8]),
        .out_valid(out_valid), .out_ready(out_ready),
        .pix_out(pix_out), .div_zero(div_zero)
    );

    stage6 #(.ROUND(1'b0)) dut_t (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t),
        .cp1(cp[0]), .cp2(cp[1]), .cp3(cp[2]), .cp4(cp[3]), .cp5(cp[4]),
        .cp6(cp[5]), .cp7(cp[6]), .cp8(cp[7]), .cp9(cp[8]),
        .c1(c[0]), .c2(c[1]), .c3(c[2]), .c4(c[3]), .c5(c[4]),
        .c6(c[5]), .c7(c[6]), .c8(c[7]), .c9(c[8]),
        .out_valid(out_valid_t), .out_ready(out_ready),
        .pix_out(pix_out_t), .div_zero(div_zero_t)
    );

    // Presents the current window for one accepting edge, then counts edges
    // (the accepting edge is edge 1) until out_valid is seen, capped at 50.
    task automatic send_window(output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin cp[i] = '0; c[i] = '0; end
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || pix_out !== 8'd0 || div_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got out_valid=%b pix_out=%0d div_zero=%b, need 0/0/0", out_valid, pix_out, div_zero);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, need 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_uniform;
        int lat;
        for (int i = 0; i < 9; i++) begin c[i] = 8'd1; cp[i] = 16'(10 * (i + 1)); end
        send_window(lat);
        checks++;
        if (lat !== 10) begin
            failures++;
            $display("FAIL uniform_latency: got %0d edges, need 10", lat);
        end
        checks++;
        if (pix_out !== 8'd50 || div_zero !== 1'b0) begin
            failures++;
            $display("FAIL uniform_value: got pix_out=%0d div_zero=%b, need 50/0", pix_out, div_zero);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL uniform_handoff: got out_valid=%b in_ready=%b, need 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_rounding;
        int lat;
        for (int i = 0; i < 9; i++) begin c[i] = (i < 4) ? 8'd1 : 8'd0; cp[i] = 16'd0; end
        cp[0] = 16'd3; cp[1] = 16'd3; cp[2] = 16'd4; cp[3] = 16'd4;
        send_window(lat);
        checks++;
        if (pix_out !== 8'd4 || lat !== 10) begin
            failures++;
            $display("FAIL round_nearest: got pix_out=%0d lat=%0d, need 4/10", pix_out, lat);
        end
        checks++;
        if (pix_out_t !== 8'd3 || out_valid_t !== 1'b1) begin
            failures++;
            $display("FAIL round_truncate: got pix_out=%0d out_valid=%b, need 3/1", pix_out_t, out_valid_t);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mixed;
        int lat;
        int cw [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        int pw [9] = '{0, 50, 100, 150, 200, 250, 10, 20, 30};
        for (int i = 0; i < 9; i++) begin c[i] = 8'(cw[i]); cp[i] = 16'(cw[i] * pw[i]); end
        send_window(lat);
        checks++;
        if (pix_out !== 8'd118 || pix_out_t !== 8'd117) begin
            failures++;
            $display("FAIL mixed_value: got round=%0d trunc=%0d, need 118/117", pix_out, pix_out_t);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_div_zero;
        int lat;
        for (int i = 0; i < 9; i++) begin c[i] = 8'd0; cp[i] = 16'd0; end
        send_window(lat);
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("FAIL zero_latency: got %0d edges, need 2", lat);
        end
        checks++;
        if (pix_out !== 8'd0 || div_zero !== 1'b1 || div_zero_t !== 1'b1) begin
            failures++;
            $display("FAIL zero_value: got pix_out=%0d div_zero=%b/%b, need 0/1/1", pix_out, div_zero, div_zero_t);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) begin c[i] = 8'd2; cp[i] = 16'd140; end
        send_window(lat);
        checks++;
        if (pix_out !== 8'd70 || div_zero !== 1'b0 || lat !== 10) begin
            failures++;
            $display("FAIL zero_recover: got pix_out=%0d div_zero=%b lat=%0d, need 70/0/10", pix_out, div_zero, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_max;
        int lat;
        for (int i = 0; i < 9; i++) begin c[i] = 8'd255; cp[i] = 16'd65025; end
        send_window(lat);
        checks++;
        if (pix_out !== 8'd255 || div_zero !== 1'b0 || pix_out_t !== 8'd255) begin
            failures++;
            $display("FAIL max_value: got round=%0d trunc=%0d div_zero=%b, need 255/255/0", pix_out, pix_out_t, div_zero);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        int lat;
        int bad;
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin c[i] = 8'd1; cp[i] = 16'd33; end
        send_window(lat);
        checks++;
        if (lat !== 10 || pix_out !== 8'd33) begin
            failures++;
            $display("FAIL bp_first: got lat=%0d pix_out=%0d, need 10/33", lat, pix_out);
        end
        for (int i = 0; i < 9; i++) cp[i] = 16'd200;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = k[0];
            if (out_valid !== 1'b1 || pix_out !== 8'd33 || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL bp_hold: got %0d bad cycles, need 0", bad);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || pix_out !== 8'd33) begin
            failures++;
            $display("FAIL bp_release: got out_valid=%b in_ready=%b pix_out=%0d, need 0/1/33", out_valid, in_ready, pix_out);
        end
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL bp_no_ghost: got %0d cycles with a stray window, need 0", bad);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        for (int i = 0; i < 9; i++) begin c[i] = 8'd3; cp[i] = 16'd300; end
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Edge 2 is ACC; edges 3..5 are the first three DIV cycles.
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || pix_out !== 8'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_clear: got out_valid=%b pix_out=%0d in_ready=%b, need 0/0/1", out_valid, pix_out, in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        lat = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid !== 1'b0) lat++;
        end
        checks++;
        if (lat !== 0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_abort: got %0d valid cycles in_ready=%b, need 0/1", lat, in_ready);
        end
        send_window(lat);
        checks++;
        if (pix_out !== 8'd100 || lat !== 10 || div_zero !== 1'b0) begin
            failures++;
            $display("FAIL midreset_next: got pix_out=%0d lat=%0d div_zero=%b, need 100/10/0", pix_out, lat, div_zero);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_uniform;
        test_rounding;
        test_mixed;
        test_div_zero;
        test_max;
        test_backpressure;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
